cordic_sincos_unit: RTL

- Parametrised successor to the single-output CORDIC instruction: an iterative rotation-mode CORDIC that returns sin and cos together from one request.
- Takes a fixed-point angle over the full range [-pi, pi] and folds it internally into [-pi/2, pi/2] before rotating.
- Datapath width and iteration count are set by parameters; out-of-range angles are rejected early.
- Sits behind the custom-instruction/peripheral glue; that glue handles any FP conversion.

---
 rtl/cordic_sincos_unit_if.sv | 56 +++++
 rtl/cordic_sincos_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_unit_if.sv
// -----------------------------------------------------------------------------
// cordic_sincos_unit_if
// Request/response bundle for cordic_sincos_unit.
//   clk_en             : clock enable, everything in the unit advances only when high
//   start / theta      : request strobe and signed angle, Q3.(WIDTH-3) radians
//   busy / done        : request in flight / one-enabled-cycle result pulse
//   cos_out / sin_out  : signed results, Q2.(WIDTH-2), held until the next done
//   input_invalid_flag : theta was outside [-pi, pi], held until the next done
//   overrun            : only with CORDIC_OVERRUN_EN; sticky "start while busy"
// Modports: master drives requests, slave is the unit.
// -----------------------------------------------------------------------------
interface cordic_sincos_unit_if #(
  parameter int WIDTH = 19
);
  logic             clk_en;
  logic             start;
  logic [WIDTH-1:0] theta;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] cos_out;
  logic [WIDTH-1:0] sin_out;
  logic             input_invalid_flag;
`ifdef CORDIC_OVERRUN_EN
  logic             overrun;
`endif

  modport master (
    output clk_en,
    output start,
    output theta,
    input  busy,
    input  done,
    input  cos_out,
    input  sin_out,
    input  input_invalid_flag
`ifdef CORDIC_OVERRUN_EN
    ,
    input  overrun
`endif
  );

  modport slave (
    input  clk_en,
    input  start,
    input  theta,
    output busy,
    output done,
    output cos_out,
    output sin_out,
    output input_invalid_flag
`ifdef CORDIC_OVERRUN_EN
    ,
    output overrun
`endif
  );
endinterface

// File: rtl/cordic_sincos_unit.sv
// -----------------------------------------------------------------------------
// cordic_sincos_unit
// Iterative rotation-mode CORDIC returning sin and cos of one angle together.
// The angle (Q3.(WIDTH-3), full range [-pi, pi]) is folded into [-pi/2, pi/2]
// before rotating; results are negated back when folded. Out-of-range angles
// skip rotation and finish on the first enabled edge with zero results.
//
// Parameters:
//   WIDTH : angle/result width, 12..32
//   ITER  : iterations, 4..min(WIDTH-2, 31)
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : cordic_sincos_unit_if.slave (clk_en, start, theta, busy, done,
//           cos_out, sin_out, input_invalid_flag[, overrun])
// Optional feature macro: CORDIC_OVERRUN_EN adds the sticky overrun output.
// -----------------------------------------------------------------------------
module cordic_sincos_unit #(
  parameter int WIDTH = 19,
  parameter int ITER  = 16
) (
  input logic                 clk,
  input logic                 reset,
  cordic_sincos_unit_if.slave bus
);

  localparam int SH = 32 - WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [4:0] ITER_LAST = 5'(ITER - 1);

  // atan(2^-i) in Q3.29
  localparam logic [31:0] ATAN_TAB [0:31] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

  // Narrow a 32-bit constant by SH fractional bits: arithmetic shift, round half up.
  function automatic logic signed [WIDTH:0] shift_q(input logic [31:0] c);
    logic signed [33:0] t;
    t = $signed({{2{c[31]}}, c});
    if (SH > 0) t = (t + (34'sd1 <<< (SH - 1))) >>> SH;
    return t[WIDTH:0];
  endfunction

  localparam logic signed [WIDTH:0] PI_Z  = shift_q(32'h6487ED51);
  localparam logic signed [WIDTH:0] PI2_Z = shift_q(32'h3243F6A9);
  localparam logic signed [WIDTH:0] K_Z   = shift_q(32'h26DD3B6A);

  localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
    logic signed [WIDTH+1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX;
    else if (v < SAT_MIN) r = SAT_MIN;
    else                  r = v;
    return r[WIDTH-1:0];
  endfunction

  logic [1:0]               r_state;
  logic                     r_busy;
  logic                     r_done;
  logic [WIDTH-1:0]         r_cos;
  logic [WIDTH-1:0]         r_sin;
  logic                     r_inv_flag;
  logic signed [WIDTH+1:0]  r_x;
  logic signed [WIDTH+1:0]  r_y;
  logic signed [WIDTH:0]    r_z;
  logic [4:0]               r_iter;
  logic                     r_neg;
  logic                     r_invalid;
`ifdef CORDIC_OVERRUN_EN
  logic                     r_overrun;
`endif

  logic signed [WIDTH:0]    w_theta;
  logic                     w_invalid;
  logic signed [WIDTH:0]    w_z0;
  logic                     w_neg;
  logic                     w_accept;
  logic signed [WIDTH:0]    w_atan;
  logic signed [WIDTH+1:0]  w_x_sh;
  logic signed [WIDTH+1:0]  w_y_sh;
  logic signed [WIDTH+1:0]  w_x_fin;
  logic signed [WIDTH+1:0]  w_y_fin;

  assign w_theta   = $signed({bus.theta[WIDTH-1], bus.theta});
  assign w_invalid = (w_theta > PI_Z) || (w_theta < -PI_Z);
  assign w_accept  = bus.start & ~r_busy;

  // Fold into [-pi/2, pi/2]; a half-turn shift flips the sign of both results.
  always_comb begin
    w_z0  = w_theta;
    w_neg = 1'b0;
    if (w_theta > PI2_Z) begin
      w_z0  = w_theta - PI_Z;
      w_neg = 1'b1;
    end else if (w_theta < -PI2_Z) begin
      w_z0  = w_theta + PI_Z;
      w_neg = 1'b1;
    end
  end

  assign w_atan  = shift_q(ATAN_TAB[r_iter]);
  assign w_x_sh  = r_x >>> r_iter;
  assign w_y_sh  = r_y >>> r_iter;
  assign w_x_fin = r_neg ? -r_x : r_x;
  assign w_y_fin = r_neg ? -r_y : r_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cos      <= '0;
      r_sin      <= '0;
      r_inv_flag <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_iter     <= '0;
      r_neg      <= 1'b0;
      r_invalid  <= 1'b0;
`ifdef CORDIC_OVERRUN_EN
      r_overrun  <= 1'b0;
`endif
    end else if (bus.clk_en) begin
`ifdef CORDIC_OVERRUN_EN
      if (bus.start && r_busy) r_overrun <= 1'b1;
      else if (w_accept)       r_overrun <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_x       <= {K_Z[WIDTH], K_Z};
            r_y       <= '0;
            r_z       <= w_z0;
            r_iter    <= '0;
            r_neg     <= w_neg;
            r_invalid <= w_invalid;
            r_busy    <= 1'b1;
            r_state   <= w_invalid ? ST_FINISH : ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          // Rotate toward z = 0: positive residual angle turns counter-clockwise.
          if (!r_z[WIDTH]) begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end
          r_iter <= r_iter + 5'd1;
          if (r_iter == ITER_LAST) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_cos      <= r_invalid ? '0 : sat(w_x_fin);
          r_sin      <= r_invalid ? '0 : sat(w_y_fin);
          r_inv_flag <= r_invalid;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.cos_out            = r_cos;
  assign bus.sin_out            = r_sin;
  assign bus.input_invalid_flag = r_inv_flag;
`ifdef CORDIC_OVERRUN_EN
  assign bus.overrun            = r_overrun;
`endif

endmodule
